rom_angle_sequencer: RTL and testbench

- Read controller and stream adapter that sits directly in front of the single-port angle ROM (MEM_WIDTH x MEM_DEPTH, synchronous read, 1-cycle latency).
- Each command names a start address and an entry count. The block generates the ROM enable and address, absorbs the read latency, and emits the entries in order on a valid/ready stream.
- Downstream backpressure is handled by a 2-entry output buffer.
- Address wrap-around at MEM_DEPTH lets a run cross the end of the table.

---
 rtl/rom_angle_sequencer.sv | 154 +++++++++++++++
 tb/tb_rom_angle_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rom_angle_sequencer.sv
// Read controller and stream adapter in front of the single-port angle ROM.
// A command (start_addr, length) is turned into a run of ROM reads whose
// 1-cycle read latency is absorbed by a 2-entry output buffer. The entries
// leave in order on a valid/ready stream, with out_last on the final one.
//
// Ports:
//   clock, rst_n           clock and asynchronous active-low reset
//   start                  command strobe, sampled only while idle
//   start_addr, length     first ROM address and entry count of the run
//   rom_enable, rom_address ROM read request (combinational from state)
//   rom_dout               ROM read data, valid the cycle after rom_enable
//   out_data, out_valid,
//   out_ready, out_last    output stream
//   busy                   high whenever a command is being processed
//   done                   one-cycle pulse at run completion
module rom_angle_sequencer #(
  parameter int unsigned MEM_WIDTH = 16,
  parameter int unsigned MEM_DEPTH = 20
) (
  input  logic                         clock,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [$clog2(MEM_DEPTH)-1:0] start_addr,
  input  logic [$clog2(MEM_DEPTH+1)-1:0] length,
  output logic                         rom_enable,
  output logic [$clog2(MEM_DEPTH)-1:0] rom_address,
  input  logic [MEM_WIDTH-1:0]         rom_dout,
  output logic [MEM_WIDTH-1:0]         out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned LW = $clog2(MEM_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic                 last;
    logic [MEM_WIDTH-1:0] data;
  } entry_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   issued_q;
  logic            in_flight_q;
  logic            flight_last_q;
  entry_t          fifo_q [2];
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      count_q;

  logic [AW-1:0]   addr_eff_c;
  logic [LW-1:0]   len_eff_c;
  logic            pop_c;
  logic            issue_c;
  logic [2:0]      occ_c;
  entry_t          head_c;

  // Out-of-range commands are sanitised before being latched
  assign addr_eff_c = (32'(start_addr) >= MEM_DEPTH) ? '0 : start_addr;
  assign len_eff_c  = (32'(length) > MEM_DEPTH) ? LW'(MEM_DEPTH) : length;

  assign head_c = fifo_q[rd_ptr_q];
  assign pop_c  = (count_q != 2'd0) && out_ready;

  // Buffer slots still committed after this cycle's pop, counting the read in flight
  assign occ_c   = 3'(count_q) - 3'(pop_c) + 3'(in_flight_q);
  assign issue_c = (state_q == RUN) && (issued_q < len_q) && (occ_c < 3'd2);

  assign rom_enable  = issue_c;
  assign rom_address = ptr_q;
  assign out_valid   = (count_q != 2'd0);
  assign out_data    = head_c.data;
  assign out_last    = out_valid && head_c.last;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FIN);

  // State register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = (len_eff_c == '0) ? FIN : RUN;
      RUN:  if (pop_c && head_c.last) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch, issue pointer and in-flight tracking
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= '0;
      len_q         <= '0;
      issued_q      <= '0;
      in_flight_q   <= 1'b0;
      flight_last_q <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        ptr_q    <= addr_eff_c;
        len_q    <= len_eff_c;
        issued_q <= '0;
      end else if (issue_c) begin
        ptr_q    <= (32'(ptr_q) == MEM_DEPTH - 1) ? '0 : ptr_q + AW'(1);
        issued_q <= issued_q + LW'(1);
      end
      in_flight_q   <= issue_c;
      flight_last_q <= issue_c && ((issued_q + LW'(1)) == len_q);
    end
  end

  // Two-entry output buffer; the in-flight ROM word is captured the cycle after issue
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (in_flight_q) begin
        fifo_q[wr_ptr_q] <= '{last: flight_last_q, data: rom_dout};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_c) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(in_flight_q) - 2'(pop_c);
    end
  end

`ifndef SYNTHESIS
  // The issue throttle guarantees a free slot for every captured word
  a_no_overflow: assert property (@(posedge clock) disable iff (!rst_n)
    !(in_flight_q && !pop_c && count_q == 2'd2));
`endif

endmodule

// File: tb/tb_rom_angle_sequencer.sv
// Bench for rom_angle_sequencer: behavioural ROM, table of directed commands,
// randomized commands, and hand-written reset / ignored-start sequences.
module tb_rom_angle_sequencer;

  localparam int unsigned MW = 16;
  localparam int unsigned MD = 20;
  localparam int unsigned AW = $clog2(MD);
  localparam int unsigned LW = $clog2(MD + 1);

  logic          clock = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] length;
  logic          rom_enable;
  logic [AW-1:0] rom_address;
  logic [MW-1:0] rom_dout;
  logic [MW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [MW-1:0] mem [MD];

  int n_cmp = 0;
  int n_fail = 0;

  rom_angle_sequencer #(.MEM_WIDTH(MW), .MEM_DEPTH(MD)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .length(length), .rom_enable(rom_enable), .rom_address(rom_address),
    .rom_dout(rom_dout), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Synchronous-read ROM model
  always @(posedge clock) begin
    if (rom_enable) rom_dout <= mem[rom_address];
  end

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Runs one command; the expected stream is the table slice from the
  // sanitised start address, wrapping modulo the ROM depth.
  task automatic run_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l,
                         input int mode, input bit poke, output int n_out,
                         output logic [MW-1:0] first_d, output logic [MW-1:0] last_d);
    int ea, el, cyc, issues, hs, last_hs, first_hs;
    bit done_seen, prev_stall, r;
    logic [MW-1:0] prev_data, e;
    logic [MW-1:0] expq [$];
    int patt [6] = '{1, 0, 0, 1, 0, 1};
    ea = (int'(a) >= MD) ? 0 : int'(a);
    el = (int'(l) > MD) ? MD : int'(l);
    for (int i = 0; i < el; i++) expq.push_back(mem[(ea + i) % MD]);
    first_d = '0; last_d = '0;
    @(negedge clock);
    start = 1'b1; start_addr = a; length = l; out_ready = 1'b1;
    #1 chk(busy == 1'b0, "idle_before_start", 32'(busy), 0);
    @(negedge clock);
    cyc = 0; issues = 0; hs = 0; last_hs = -10; first_hs = -10;
    done_seen = 0; prev_stall = 0; prev_data = '0;
    while (!done_seen && cyc < 300) begin
      case (mode)
        0: r = 1'b1;
        1: r = patt[cyc % 6] != 0;
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (poke && cyc == 2) begin
        start = 1'b1; start_addr = 5'd19; length = 5'd2;
      end else begin
        start = 1'b0;
      end
      out_ready = r;
      #1;
      if (rom_enable) begin
        chk(32'(rom_address) == 32'((ea + issues) % MD), "rom_address",
            32'(rom_address), 32'((ea + issues) % MD));
        issues++;
        chk(issues <= el, "issue_count", 32'(issues), 32'(el));
      end
      if (prev_stall) begin
        chk(out_valid && out_data == prev_data, "stall_hold", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        e = (expq.size() > 0) ? expq.pop_front() : 'x;
        chk(out_data === e, "out_data", 32'(out_data), 32'(e));
        chk(out_last == (hs == el - 1), "out_last", 32'(out_last), 32'(hs == el - 1));
        if (hs == 0) begin first_d = out_data; first_hs = cyc; end
        last_d = out_data;
        hs++;
        last_hs = cyc;
      end
      chk(issues - hs <= 2, "outstanding_le2", 32'(issues - hs), 2);
      if (done) begin
        done_seen = 1;
        if (el == 0) chk(cyc <= 1, "done_len0_latency", 32'(cyc), 1);
        else chk(cyc == last_hs + 1, "done_after_last", 32'(cyc), 32'(last_hs + 1));
        chk(busy == 1'b1, "busy_with_done", 32'(busy), 1);
        chk(hs == el && issues == el, "entries_total", 32'(hs), 32'(el));
        if (mode == 0 && el > 0)
          chk(last_hs - first_hs == el - 1, "throughput", 32'(last_hs - first_hs), 32'(el - 1));
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      cyc++;
      @(negedge clock);
    end
    start = 1'b0;
    if (!done_seen) chk(1'b0, "done_timeout", 32'(cyc), 300);
    #1;
    chk(busy == 1'b0 && done == 1'b0, "idle_after_done", {busy, done}, 0);
    n_out = hs;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    int            mode;
    bit            poke;
    int            exp_n;
    logic [MW-1:0] exp_first;
    logic [MW-1:0] exp_last;
  } vec_t;

  initial begin
    vec_t vecs [8];
    int n;
    logic [MW-1:0] f, la;

    for (int i = 0; i < MD; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1fdf; mem[1] = 16'h1bff; mem[2] = 16'h0aff;
    mem[3] = 16'h0c3a; mem[19] = 16'h1b4f;

    vecs[0] = '{5'd0,  5'd3,  0, 1'b0, 3,  16'h1fdf, 16'h0aff};
    vecs[1] = '{5'd19, 5'd3,  0, 1'b0, 3,  16'h1b4f, 16'h1bff};
    vecs[2] = '{5'd0,  5'd4,  1, 1'b0, 4,  16'h1fdf, 16'h0c3a};
    vecs[3] = '{5'd0,  5'd20, 0, 1'b0, 20, 16'h1fdf, 16'h1b4f};
    vecs[4] = '{5'd0,  5'd0,  0, 1'b0, 0,  16'h0000, 16'h0000};
    vecs[5] = '{5'd0,  5'd4,  0, 1'b1, 4,  16'h1fdf, 16'h0c3a};
    vecs[6] = '{5'd25, 5'd2,  0, 1'b0, 2,  16'h1fdf, 16'h1bff};
    vecs[7] = '{5'd1,  5'd31, 2, 1'b0, 20, 16'h1bff, 16'h1fdf};

    rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; out_ready = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    chk(!rom_enable && rom_address == '0, "reset_rom", {rom_enable, 31'(rom_address)}, 0);
    chk(!out_valid && !out_last && out_data == '0, "reset_out", 32'(out_data), 0);
    chk(!busy && !done, "reset_status", {busy, done}, 0);
    @(negedge clock);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      run_cmd(vecs[v].addr, vecs[v].len, vecs[v].mode, vecs[v].poke, n, f, la);
      chk(n == vecs[v].exp_n, "vec_count", 32'(n), 32'(vecs[v].exp_n));
      if (vecs[v].exp_n > 0) begin
        chk(f == vecs[v].exp_first, "vec_first", 32'(f), 32'(vecs[v].exp_first));
        chk(la == vecs[v].exp_last, "vec_last", 32'(la), 32'(vecs[v].exp_last));
      end
    end

    // Reset while the buffer holds data, then a clean run from a new address
    @(negedge clock);
    start = 1'b1; start_addr = 5'd0; length = 5'd20; out_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clock);
    chk(out_valid == 1'b1, "midrun_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk(!out_valid && !out_last && out_data == '0, "midrun_reset_out", 32'(out_data), 0);
    chk(!rom_enable && rom_address == '0, "midrun_reset_rom", 32'(rom_address), 0);
    chk(!busy && !done, "midrun_reset_status", {busy, done}, 0);
    @(negedge clock);
    rst_n = 1'b1;
    run_cmd(5'd19, 5'd3, 0, 1'b0, n, f, la);
    chk(n == 3 && f == 16'h1b4f && la == 16'h1bff, "after_reset_run", 32'(f), 32'h1b4f);

    // Randomized commands against the scoreboard, random backpressure
    for (int k = 0; k < 25; k++) begin
      run_cmd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 2, 1'b0, n, f, la);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
